ipu_resp_queue: RTL and testbench

- Credit-throttled response queue between the Snitch accelerator port and the integer processing unit (IPU).
- Request channel passes through combinationally, gated by an outstanding-request counter.
- IPU results (data, id, error) are buffered in a Depth-entry FIFO, so the IPU is never back-pressured by a stalled core writeback.
- Guarantees at most Depth requests in flight between IPU acceptance and core retirement.

---
 rtl/ipu_resp_queue.sv | 111 +++++++++++
 tb/tb_ipu_resp_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ipu_resp_queue.sv
// Credit-throttled response queue between the accelerator port and the IPU.
// Requests pass straight through, gated by an in-flight credit count; IPU
// results land in a small circular FIFO whose head drives the core writeback.
module ipu_resp_queue #(
  parameter int unsigned IdWidth   = 5,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         core_qvalid_i,
  output logic                         core_qready_o,
  output logic                         ipu_qvalid_o,
  input  logic                         ipu_qready_i,
  input  logic [DataWidth-1:0]         ipu_pdata_i,
  input  logic [IdWidth-1:0]           ipu_pid_i,
  input  logic                         ipu_perror_i,
  input  logic                         ipu_pvalid_i,
  output logic                         ipu_pready_o,
  output logic [DataWidth-1:0]         core_pdata_o,
  output logic [IdWidth-1:0]           core_pid_o,
  output logic                         core_perror_o,
  output logic                         core_pvalid_o,
  input  logic                         core_pready_i,
  output logic [$clog2(Depth+1)-1:0]   outstanding_o
);

  localparam int unsigned OW = $clog2(Depth + 1);
  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(Depth);
  localparam logic [PW-1:0] LAST_P  = PW'(Depth - 1);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [IdWidth-1:0]   id;
    logic                 err;
  } entry_t;

  entry_t        mem_q [Depth];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0] cnt_q, cnt_d, out_q, out_d;

  logic credit_ok, full, empty, issue, retire, push, pop;
  entry_t head, wr_entry;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  // Handshake gating: credit only depends on registered state, so there is
  // no combinational qvalid -> qready path.
  always_comb begin
    credit_ok = (out_q < DEPTH_C);
    full      = (cnt_q == DEPTH_C);
    empty     = (cnt_q == '0);
    head      = mem_q[rptr_q];
    wr_entry  = '{data: ipu_pdata_i, id: ipu_pid_i, err: ipu_perror_i};
    push      = ipu_pvalid_i & ~full;
    pop       = ~empty & core_pready_i;
    issue     = core_qvalid_i & ipu_qready_i & credit_ok;
    retire    = pop;
  end

  assign ipu_qvalid_o  = core_qvalid_i & credit_ok;
  assign core_qready_o = ipu_qready_i & credit_ok;
  assign ipu_pready_o  = ~full;
  assign core_pvalid_o = ~empty;
  assign core_pdata_o  = head.data;
  assign core_pid_o    = head.id;
  assign core_perror_o = head.err;
  assign outstanding_o = out_q;

  // Next-state for pointers, FIFO usage and in-flight count.
  always_comb begin
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + OW'(1);
    else if (!push && pop) cnt_d = cnt_q - OW'(1);
    out_d  = out_q;
    if (issue && !retire)      out_d = out_q + OW'(1);
    else if (!issue && retire) out_d = out_q - OW'(1);
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      if (push) mem_q[wptr_q] <= wr_entry;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  // Protocol checks: a retire needs a credit, the credit invariant keeps the
  // FIFO from being full under a response, and every response needs an issue.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(retire && out_q == '0));
  a_no_full_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ipu_pvalid_i && full));
  a_rsp_has_issue: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (int'(out_q) + int'(issue) <= int'(cnt_q))));

endmodule

// File: tb/tb_ipu_resp_queue.sv
// Bench for ipu_resp_queue: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a queue-based model.
module tb_ipu_resp_queue;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        core_qvalid_i, core_qready_o, ipu_qvalid_o, ipu_qready_i;
  logic [31:0] ipu_pdata_i;
  logic [4:0]  ipu_pid_i;
  logic        ipu_perror_i, ipu_pvalid_i, ipu_pready_o;
  logic [31:0] core_pdata_o;
  logic [4:0]  core_pid_o;
  logic        core_perror_o, core_pvalid_o, core_pready_i;
  logic [1:0]  outstanding_o;

  ipu_resp_queue #(.IdWidth(5), .DataWidth(32), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_qvalid_i(core_qvalid_i), .core_qready_o(core_qready_o),
    .ipu_qvalid_o(ipu_qvalid_o), .ipu_qready_i(ipu_qready_i),
    .ipu_pdata_i(ipu_pdata_i), .ipu_pid_i(ipu_pid_i),
    .ipu_perror_i(ipu_perror_i), .ipu_pvalid_i(ipu_pvalid_i),
    .ipu_pready_o(ipu_pready_o),
    .core_pdata_o(core_pdata_o), .core_pid_o(core_pid_o),
    .core_perror_o(core_perror_o), .core_pvalid_o(core_pvalid_o),
    .core_pready_i(core_pready_i), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [4:0] id; logic e; } rsp_t;

  // Model: responses held for the core, requests issued but not yet answered
  // by the bench IPU, and the number of issued-but-unretired requests.
  rsp_t fq[$];
  rsp_t pend[$];
  int   outs;
  bit   rnd_mode;
  int   n_cmp, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("core_qready", 32'(core_qready_o), 32'(ipu_qready_i && outs < DEPTH));
    chk("ipu_qvalid", 32'(ipu_qvalid_o), 32'(core_qvalid_i && outs < DEPTH));
    chk("ipu_pready", 32'(ipu_pready_o), 32'(fq.size() < DEPTH));
    chk("core_pvalid", 32'(core_pvalid_o), 32'(fq.size() > 0));
    chk("outstanding", 32'(outstanding_o), 32'(outs));
    if (fq.size() > 0) begin
      chk("core_pdata", core_pdata_o, fq[0].d);
      chk("core_pid", 32'(core_pid_o), 32'(fq[0].id));
      chk("core_perror", 32'(core_perror_o), 32'(fq[0].e));
    end
  endtask

  task automatic model_update();
    bit   issue, retire, push;
    rsp_t r;
    issue  = core_qvalid_i && ipu_qready_i && outs < DEPTH;
    retire = fq.size() > 0 && core_pready_i;
    push   = ipu_pvalid_i && fq.size() < DEPTH;
    if (retire) void'(fq.pop_front());
    if (push) begin
      r.d = ipu_pdata_i; r.id = ipu_pid_i; r.e = ipu_perror_i;
      fq.push_back(r);
    end
    outs = outs + int'(issue) - int'(retire);
    if (rnd_mode && push && pend.size() > 0) void'(pend.pop_front());
    if (rnd_mode && issue) begin
      r.d = $urandom; r.id = 5'($urandom_range(0, 31)); r.e = ($urandom_range(0, 7) == 0);
      pend.push_back(r);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, hand control back just after it so inputs change away from edges.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    ipu_pvalid_i = 1'b0;
    core_pready_i = 1'b0;
    #1;
    chk("rst_pvalid", 32'(core_pvalid_o), 32'd0);
    chk("rst_pdata", core_pdata_o, 32'd0);
    chk("rst_pid", 32'(core_pid_o), 32'd0);
    chk("rst_perror", 32'(core_perror_o), 32'd0);
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    fq.delete(); pend.delete(); outs = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  task automatic idle_inputs();
    core_qvalid_i = 0; ipu_qready_i = 1; ipu_pvalid_i = 0; core_pready_i = 0;
    ipu_pdata_i = '0; ipu_pid_i = '0; ipu_perror_i = 0;
  endtask

  task automatic pair_test(input logic [31:0] d, input logic [4:0] id);
    core_qvalid_i = 1; ipu_qready_i = 1;
    tick();
    core_qvalid_i = 0;
    ipu_pvalid_i = 1; ipu_pdata_i = d; ipu_pid_i = id; ipu_perror_i = 0;
    #2 chk("pair_no_fallthrough", 32'(core_pvalid_o), 32'd0);
    tick();
    ipu_pvalid_i = 0; core_pready_i = 1;
    #2;
    chk("pair_pvalid", 32'(core_pvalid_o), 32'd1);
    chk("pair_pdata", core_pdata_o, d);
    chk("pair_pid", 32'(core_pid_o), 32'(id));
    chk("pair_outs1", 32'(outstanding_o), 32'd1);
    tick();
    #2;
    chk("pair_pvalid_done", 32'(core_pvalid_o), 32'd0);
    chk("pair_outs0", 32'(outstanding_o), 32'd0);
    core_pready_i = 0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; rnd_mode = 0; outs = 0;
    idle_inputs();
    rst_ni = 0;

    // Credit limit: qvalid held through reset, two back-to-back issues.
    core_qvalid_i = 1; ipu_qready_i = 1;
    do_reset();
    #2 chk("t1_qready_after_rst", 32'(core_qready_o), 32'd1);
    tick(); tick();
    #2;
    chk("t1_outs2", 32'(outstanding_o), 32'd2);
    chk("t1_qready_blocked", 32'(core_qready_o), 32'd0);
    chk("t1_ipu_qvalid_blocked", 32'(ipu_qvalid_o), 32'd0);
    tick();

    // Single issue/response, latency and id/data integrity.
    idle_inputs(); do_reset();
    pair_test(32'h0000_002A, 5'd5);

    // Back-pressure: two buffered results, head stable while stalled.
    idle_inputs(); do_reset();
    core_qvalid_i = 1; tick(); tick(); core_qvalid_i = 0;
    ipu_pvalid_i = 1; ipu_pdata_i = 32'h11; ipu_pid_i = 5'd1; tick();
    ipu_pdata_i = 32'h22; ipu_pid_i = 5'd2; tick();
    ipu_pvalid_i = 0;
    #2 chk("t3_ipu_pready_full", 32'(ipu_pready_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_head_data", core_pdata_o, 32'h11);
      chk("t3_head_id", 32'(core_pid_o), 32'd1);
      tick();
    end
    core_pready_i = 1;
    #2 chk("t3_first", core_pdata_o, 32'h11);
    tick();
    #2 chk("t3_second", core_pdata_o, 32'h22);
    tick();
    #2 chk("t3_drained", 32'(outstanding_o), 32'd0);

    // Steady state: same-cycle IPU answer, issue and retire every cycle.
    idle_inputs(); do_reset();
    for (int i = 0; i < 21; i++) begin
      core_qvalid_i = 1; ipu_qready_i = 1; core_pready_i = 1;
      ipu_pvalid_i = 1; ipu_pdata_i = 32'(i * 3 + 7); ipu_pid_i = 5'(i);
      #2;
      if (i > 0) begin
        chk("t4_outs", 32'(outstanding_o), 32'd1);
        chk("t4_qready", 32'(core_qready_o), 32'd1);
        chk("t4_pdata", core_pdata_o, 32'((i - 1) * 3 + 7));
      end
      tick();
    end
    core_qvalid_i = 0; ipu_pvalid_i = 0;
    tick();
    #2 chk("t4_drained", 32'(outstanding_o), 32'd0);

    // Error flag travels with its entry only.
    idle_inputs(); do_reset();
    core_qvalid_i = 1; tick(); core_qvalid_i = 0;
    ipu_pvalid_i = 1; ipu_pdata_i = 32'h33; ipu_pid_i = 5'd3; ipu_perror_i = 1; tick();
    ipu_pvalid_i = 0; ipu_perror_i = 0; core_pready_i = 1; core_qvalid_i = 1;
    #2;
    chk("t5_err1", 32'(core_perror_o), 32'd1);
    chk("t5_id3", 32'(core_pid_o), 32'd3);
    tick();
    core_qvalid_i = 0; core_pready_i = 0;
    ipu_pvalid_i = 1; ipu_pdata_i = 32'h44; ipu_pid_i = 5'd4; tick();
    ipu_pvalid_i = 0; core_pready_i = 1;
    #2;
    chk("t5_err0", 32'(core_perror_o), 32'd0);
    chk("t5_id4", 32'(core_pid_o), 32'd4);
    chk("t5_outs1", 32'(outstanding_o), 32'd1);
    tick();
    #2 chk("t5_outs0", 32'(outstanding_o), 32'd0);

    // Reset mid-stream: 2 outstanding, 1 buffered, then a clean pair.
    idle_inputs(); do_reset();
    core_qvalid_i = 1; tick(); tick(); core_qvalid_i = 0;
    ipu_pvalid_i = 1; ipu_pdata_i = 32'h55; ipu_pid_i = 5'd9; tick();
    ipu_pvalid_i = 0;
    #2;
    chk("t6_outs2", 32'(outstanding_o), 32'd2);
    chk("t6_buffered", 32'(core_pvalid_o), 32'd1);
    do_reset();
    pair_test(32'h66, 5'd7);

    // Randomized traffic with an in-order bench IPU of variable latency.
    idle_inputs(); do_reset();
    rnd_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      core_qvalid_i = ($urandom_range(0, 3) != 0);
      ipu_qready_i  = ($urandom_range(0, 4) != 0);
      core_pready_i = ($urandom_range(0, 3) != 0);
      if (pend.size() > 0 && fq.size() < DEPTH && $urandom_range(0, 2) != 0) begin
        ipu_pvalid_i = 1; ipu_pdata_i = pend[0].d; ipu_pid_i = pend[0].id; ipu_perror_i = pend[0].e;
      end else begin
        ipu_pvalid_i = 0; ipu_pdata_i = $urandom; ipu_pid_i = 5'($urandom_range(0, 31)); ipu_perror_i = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
